// File: rtl/inst_mem_resp_if.sv
// inst_mem_resp_if: fetch-port and program-load bundle for inst_mem_resp.
//   fetch : ce_i, addr_i (core -> mem); inst_o, stallreq_o, addr_err_o (mem -> core)
//   load  : load_start_i, load_valid_i, load_data_i, load_last_i (loader -> mem);
//           load_ready_o, load_done_o, load_cnt_o (mem -> loader)
// master = core/loader side, slave = the memory responder.
interface inst_mem_resp_if #(
    parameter int DEPTH_LOG2 = 10
);
    logic                  ce_i;
    logic [31:0]           addr_i;
    logic [31:0]           inst_o;
    logic                  stallreq_o;
    logic                  addr_err_o;
    logic                  load_start_i;
    logic                  load_valid_i;
    logic [31:0]           load_data_i;
    logic                  load_last_i;
    logic                  load_ready_o;
    logic                  load_done_o;
    logic [DEPTH_LOG2:0]   load_cnt_o;

    modport master (
        output ce_i, addr_i, load_start_i, load_valid_i, load_data_i, load_last_i,
        input  inst_o, stallreq_o, addr_err_o, load_ready_o, load_done_o, load_cnt_o
    );

    modport slave (
        input  ce_i, addr_i, load_start_i, load_valid_i, load_data_i, load_last_i,
        output inst_o, stallreq_o, addr_err_o, load_ready_o, load_done_o, load_cnt_o
    );
endinterface

// File: rtl/inst_mem_resp.sv
// inst_mem_resp: instruction memory behind the core fetch port.
//   Fetch returns mem[addr_i[DEPTH_LOG2+1:2]] combinationally while serving.
//   A streaming load port (start/valid/data/last, ready/done/cnt) rewrites the
//   program from word 0; the core is stalled for the duration of the load.
// Ports:
//   clk, rst   clock, synchronous active-high reset
//   bus        inst_mem_resp_if.slave (fetch + load signals)
// Optional build macro:
//   INST_MEM_BYTE_SWAP_EN  store every loaded word byte-reversed (little-endian
//                          loaders); fetch path is unchanged.
module inst_mem_resp #(
    parameter int DEPTH_LOG2 = 10
) (
    input  logic               clk,
    input  logic               rst,
    inst_mem_resp_if.slave     bus
);
    localparam int DEPTH = 1 << DEPTH_LOG2;

    typedef enum logic {SERVE = 1'b0, LOAD = 1'b1} state_e;

    state_e                 state_q, state_d;
    logic [DEPTH_LOG2-1:0]  ptr_q, ptr_d;
    logic [DEPTH_LOG2:0]    cnt_q, cnt_d;
    logic                   err_q, err_d;
    logic                   done_q, done_d;

    logic [31:0]            mem [DEPTH];

    logic                   start;
    logic                   accept;
    logic                   ptr_full;
    logic                   final_word;
    logic                   fetch_bad;
    logic [31:0]            wdata;

    // Handshake decode. Ready is masked during reset so a reset mid-load
    // never writes a word.
    always_comb begin
        bus.load_ready_o = (state_q == LOAD) && !rst;
        accept           = bus.load_ready_o && bus.load_valid_i;
        start            = (state_q == SERVE) && bus.load_start_i && !rst;
        ptr_full         = (ptr_q == {DEPTH_LOG2{1'b1}});
        // last word either flagged by the loader or filling the final slot
        final_word       = accept && (bus.load_last_i || ptr_full);
        fetch_bad        = (bus.addr_i[1:0] != 2'b00) ||
                           (bus.addr_i[31:DEPTH_LOG2+2] != '0);
    end

`ifdef INST_MEM_BYTE_SWAP_EN
    assign wdata = {bus.load_data_i[7:0],   bus.load_data_i[15:8],
                    bus.load_data_i[23:16], bus.load_data_i[31:24]};
`else
    assign wdata = bus.load_data_i;
`endif

    // State register and datapath flops.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= SERVE;
            ptr_q   <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            done_q  <= done_d;
        end
    end

    // Memory contents survive reset, so no reset term here.
    always_ff @(posedge clk) begin
        if (accept)
            mem[ptr_q] <= wdata;
    end

    // Next state.
    always_comb begin
        state_d = state_q;
        case (state_q)
            SERVE: if (start)      state_d = LOAD;
            LOAD:  if (final_word) state_d = SERVE;
            default:               state_d = SERVE;
        endcase
    end

    // Datapath next values.
    always_comb begin
        ptr_d  = ptr_q;
        cnt_d  = cnt_q;
        err_d  = err_q;
        done_d = final_word;
        if (state_q == SERVE && bus.ce_i && fetch_bad)
            err_d = 1'b1;
        if (start) begin
            ptr_d = '0;
            cnt_d = '0;
            err_d = 1'b0;
        end else if (accept) begin
            cnt_d = cnt_q + 1'b1;
            // pointer saturates at the top slot; the load ends there anyway
            if (!ptr_full)
                ptr_d = ptr_q + 1'b1;
        end
    end

    // Outputs.
    always_comb begin
        bus.inst_o      = '0;
        bus.stallreq_o  = !rst && (state_q == LOAD);
        if (!rst && state_q == SERVE && bus.ce_i && !fetch_bad)
            bus.inst_o = mem[bus.addr_i[DEPTH_LOG2+1:2]];
        bus.addr_err_o  = err_q;
        bus.load_done_o = done_q;
        bus.load_cnt_o  = cnt_q;
    end
endmodule

// File: doc/inst_mem_resp.md
Name: inst_mem_resp

Overview:
Instruction-memory responder on the far side of the core's fetch port. The core drives the fetch address and chip-enable; this block returns the instruction word in the same cycle.
Program contents are written through a streaming load port, controlled by a small state machine. While a load is in progress, the block raises a fetch-stall request toward the pipeline controller.
Sits beside the core top level, between the fetch port and the program loader.

Parameters:
DEPTH_LOG2, 10, log2 of memory depth in 32-bit words (default 1024 words, 4 KiB).

Ports:
clk  in  1  clock.
rst  in  1  synchronous active-high reset; one clock, sampled on rising edge of clk.
ce_i  in  1  fetch chip-enable from core.
addr_i  in  32  byte fetch address from core.
inst_o  out  32  instruction word to core.
stallreq_o  out  1  fetch stall request to pipeline controller.
addr_err_o  out  1  sticky fetch-address error flag.
load_start_i  in  1  pulse: begin program load at word 0.
load_valid_i  in  1  load data valid.
load_data_i  in  32  load data word.
load_last_i  in  1  marks final word of the load stream.
load_ready_o  out  1  block accepts a load word this cycle.
load_done_o  out  1  one-cycle pulse when a load completes.
load_cnt_o  out  DEPTH_LOG2+1  words written by the most recent load.

Behaviour:
- Reset (rst=1 at clk edge):
  - state=SERVE, load_cnt_o=0, addr_err_o=0, load_done_o=0, internal write pointer=0.
  - Memory array is NOT cleared.
  - While rst=1, inst_o=0 and stallreq_o=0 combinationally.
- State SERVE:
  - inst_o = mem[addr_i[DEPTH_LOG2+1:2]] combinationally (zero latency) when ce_i=1; inst_o=0 when ce_i=0.
  - load_ready_o=0; stallreq_o=0.
- Fetch error, in SERVE with ce_i=1, when either condition holds:
  - addr_i[1:0]!=0, or
  - addr_i[31:DEPTH_LOG2+2]!=0.
  - Response: inst_o=0 (NOP) and addr_err_o set on the next edge. It stays set until reset or the next load_start_i accept.
- SERVE -> LOAD on load_start_i=1:
  - Write pointer=0, load_cnt_o=0, addr_err_o cleared.
  - load_valid_i in the same cycle is NOT accepted.
- State LOAD:
  - load_ready_o=1, stallreq_o=1, inst_o=0 regardless of ce_i/addr_i.
  - Each cycle with load_valid_i&&load_ready_o: mem[ptr] <= word, ptr++, load_cnt_o++.
  - load_start_i is ignored in LOAD.
- LOAD -> SERVE on either:
  - an accepted word with load_last_i=1, or
  - an accepted word written to index 2^DEPTH_LOG2-1 (memory full; ptr does not wrap).
  - load_done_o pulses high for exactly the cycle after that final word's edge.
  - The first fetch served from new contents is in that same cycle; stallreq_o is 0 from then on.
- load_cnt_o holds its final value until the next load_start_i.
  - Range 1..2^DEPTH_LOG2; width DEPTH_LOG2+1 so a full load reads 1024.
- Reset mid-load: returns to SERVE next cycle.
  - Words already written stay in memory; load_cnt_o=0; no load_done_o pulse.

Optional Feature:
INST_MEM_BYTE_SWAP_EN
- Defined: every accepted load word is stored byte-reversed ({d[7:0],d[15:8],d[23:16],d[31:24]}) for little-endian loaders.
- Undefined: words are stored exactly as received.
- The fetch path is identical in both cases.

Test Plan:
- Reset, load_start_i, stream 3 words 0x34010001/0x34020002/0x00221820 with last on word 3:
  - load_done_o pulses once, load_cnt_o=3.
  - Fetch addr 0x0/0x4/0x8 returns those words the same cycle.
- During LOAD, drive ce_i=1, addr_i=0x0 -> inst_o=0, stallreq_o=1 every cycle until the cycle after the last word; then inst_o=0x34010001.
- Fetch addr_i=0x00000006 then 0x00001000 (DEPTH_LOG2=10):
  - inst_o=0 for both; addr_err_o=1 from the next edge.
  - addr_err_o stays 1 until the next load_start_i.
- Stream 1024 words without load_last_i:
  - Return to SERVE after word 1024, load_cnt_o=1024.
  - A 1025th load_valid_i is not accepted (load_ready_o=0).
- Assert rst after 2 of 5 words: SERVE next cycle, load_cnt_o=0, no load_done_o.
  - Fetch 0x4 returns the 2nd word; fetch 0x8 returns the old contents.
- With INST_MEM_BYTE_SWAP_EN defined, load 0x78563412 -> fetch 0x0 returns 0x12345678.
  - Without it, the same fetch returns 0x78563412.
